// File: rtl/conv2d_stream_engine.sv
// Streaming KxK convolution over a raster pixel stream: K-1 rotating line buffers feed a window, a
// two-stage MAC pipeline produces one saturated pixel per interior position. Optional macro CONV_ABS_EN.
module conv2d_stream_engine #(
    parameter int IMG_W  = 2048,
    parameter int IMG_H  = 2048,
    parameter int PIX_W  = 8,
    parameter int K      = 3,
    parameter int COEF_W = 8,
    parameter int SHIFT  = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [PIX_W-1:0]             in_pixel,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         coef_we,
    input  logic [$clog2(K*K)-1:0]       coef_addr,
    input  logic [COEF_W-1:0]            coef_data,
    output logic [PIX_W-1:0]             out_pixel,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last
);

    localparam int NC    = K * K;
    localparam int CAW   = $clog2(NC);
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);
    localparam int NR    = K - 1;
    localparam int RPW   = (NR > 1) ? $clog2(NR) : 1;
    localparam int PW    = PIX_W + COEF_W + 1;
    localparam int ACC_W = PIX_W + COEF_W + $clog2(NC) + 1;
    localparam int CTR   = NC / 2;

    localparam logic [XW-1:0]           X_LAST  = XW'(IMG_W - 1);
    localparam logic [YW-1:0]           Y_LAST  = YW'(IMG_H - 1);
    localparam logic [XW-1:0]           X_FIRST = XW'(K - 1);
    localparam logic [YW-1:0]           Y_FIRST = YW'(K - 1);
    localparam logic [RPW-1:0]          RP_LAST = RPW'(NR - 1);
    localparam logic [RPW:0]            NR_EXT  = (RPW + 1)'(NR);
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIX_W) - 1);

    logic                      adv;
    logic                      acc;
    logic [XW-1:0]             x;
    logic [YW-1:0]             y;
    logic [RPW-1:0]            rp;
    logic [PIX_W-1:0]          lb   [NR][IMG_W];
    logic [RPW-1:0]            rsel [NR];
    logic [PIX_W-1:0]          col  [NR];
    logic [PIX_W-1:0]          win  [K][K];
    logic                      w_vld;
    logic                      w_last;
    logic signed [COEF_W-1:0]  coef [NC];
    logic signed [PW-1:0]      prod [NC];
    logic                      s1_vld;
    logic                      s1_last;
    logic signed [ACC_W-1:0]   sum;
    logic signed [ACC_W-1:0]   sh;
    logic signed [ACC_W-1:0]   mag;
    logic [PIX_W-1:0]          res;

    // Every stage, including input acceptance, steps only when the output register can move.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign acc      = in_valid && adv;

    always_ff @(posedge clk) begin
        if (reset) begin
            x  <= '0;
            y  <= '0;
            rp <= '0;
        end else if (acc) begin
            if (x == X_LAST) begin
                x  <= '0;
                y  <= (y == Y_LAST) ? '0 : y + 1'b1;
                rp <= (rp == RP_LAST) ? '0 : rp + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    // rp names the oldest row buffer; the others follow it in age order.
    always_comb begin
        logic [RPW:0] s;
        s = '0;
        for (int r = 0; r < NR; r++) begin
            s = {1'b0, rp} + (RPW + 1)'(r);
            if (s >= NR_EXT) begin
                s = s - NR_EXT;
            end
            rsel[r] = s[RPW-1:0];
            col[r]  = lb[rsel[r]][x];
        end
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            lb[rp][x] <= in_pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win[r][c] <= win[r][c+1];
                end
            end
            for (int r = 0; r < NR; r++) begin
                win[r][K-1] <= col[r];
            end
            win[K-1][K-1] <= in_pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NC; i++) begin
                coef[i] <= (i == CTR) ? COEF_W'(1) : '0;
            end
        end else if (coef_we) begin
            for (int i = 0; i < NC; i++) begin
                if (coef_addr == CAW'(i)) begin
                    coef[i] <= coef_data;
                end
            end
        end
    end

    // Stage 1: pixels are zero-extended so they stay non-negative in the signed product.
    always_ff @(posedge clk) begin
        if (adv) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    prod[r*K+c] <= PW'($signed({1'b0, win[r][c]})) * PW'(coef[r*K+c]);
                end
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < NC; i++) begin
            sum = sum + ACC_W'(prod[i]);
        end
        sh = sum >>> SHIFT;
`ifdef CONV_ABS_EN
        mag = sh[ACC_W-1] ? -sh : sh;
`else
        mag = sh[ACC_W-1] ? '0 : sh;
`endif
        if (mag > PIX_MAX) begin
            res = PIX_MAX[PIX_W-1:0];
        end else begin
            res = mag[PIX_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_vld     <= 1'b0;
            w_last    <= 1'b0;
            s1_vld    <= 1'b0;
            s1_last   <= 1'b0;
            out_valid <= 1'b0;
            out_pixel <= '0;
            out_last  <= 1'b0;
        end else if (adv) begin
            w_vld     <= acc && (x >= X_FIRST) && (y >= Y_FIRST);
            w_last    <= acc && (x == X_LAST) && (y == Y_LAST);
            s1_vld    <= w_vld;
            s1_last   <= w_last;
            out_valid <= s1_vld;
            out_last  <= s1_vld && s1_last;
            if (s1_vld) begin
                out_pixel <= res;
            end
        end
    end

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Randomized scoreboard bench for conv2d_stream_engine on an 8x6 image with a 3x3 kernel.
module tb_conv2d_stream_engine;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int KD = 3;
    localparam int SH = 0;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_pixel;
    logic       in_valid;
    logic       in_ready;
    logic       coef_we;
    logic [3:0] coef_addr;
    logic [7:0] coef_data;
    logic [7:0] out_pixel;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    conv2d_stream_engine #(
        .IMG_W(W), .IMG_H(H), .PIX_W(8), .K(KD), .COEF_W(8), .SHIFT(SH)
    ) dut (
        .clk(clk), .reset(reset),
        .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_pixel(out_pixel), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    int         img  [H][W];
    int         kern [KD*KD];
    logic [8:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    bit ignore = 1'b0;
    bit rand_rdy = 1'b0;
    int out_cnt, last_cnt, sat_cnt, zero_cnt, first_val, last_val;
    int first_cyc, acc22_cyc;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference: direct convolution of the stored image with the current kernel.
    function automatic int model_val(input int x, input int y);
        int s = 0;
        for (int r = 0; r < KD; r++)
            for (int c = 0; c < KD; c++)
                s += kern[r*KD+c] * img[y-KD+1+r][x-KD+1+c];
        s = s >>> SH;
        if (s < 0) begin
`ifdef CONV_ABS_EN
            s = -s;
`else
            s = 0;
`endif
        end
        if (s > 255) s = 255;
        return s;
    endfunction

    task automatic clear_stats();
        out_cnt = 0; last_cnt = 0; sat_cnt = 0; zero_cnt = 0;
        first_val = -1; last_val = -1; first_cyc = -1; acc22_cyc = -1;
    endtask

    task automatic load_coef(input int idx, input int val);
        coef_we   = 1'b1;
        coef_addr = 4'(idx);
        coef_data = 8'(val);
        @(posedge clk); #1;
        coef_we = 1'b0;
        kern[idx] = val;
    endtask

    task automatic load_kernel(input int k0, input int k1, input int k2, input int k3,
                               input int k4, input int k5, input int k6, input int k7, input int k8);
        int v[9];
        v = '{k0, k1, k2, k3, k4, k5, k6, k7, k8};
        for (int i = 0; i < 9; i++) load_coef(i, v[i]);
    endtask

    task automatic fill_ramp();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = y * W + x;
    endtask

    task automatic fill_step(input bit mirrored);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = ((x >= 4) != mirrored) ? 100 : 0;
    endtask

    task automatic send_frame(input int n_pix, input bit bubbles, input bit push);
        for (int k = 0; k < n_pix; k++) begin
            int x, y, t;
            bit got;
            x = k % W;
            y = (k / W) % H;
            if (bubbles) begin
                while ($urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            in_pixel = 8'(img[y][x]);
            got = 1'b0;
            t = 0;
            while (!got && t < 200) begin
                @(negedge clk);
                got = in_ready;
                @(posedge clk); #1;
                t++;
            end
            if (!got) begin
                n_err++;
                $display("FAIL accept_timeout: pixel (%0d,%0d) not accepted, required accept within 200 cycles", x, y);
            end
            if (x == 2 && y == 2 && acc22_cyc < 0) acc22_cyc = cyc;
            if (push && x >= KD - 1 && y >= KD - 1)
                exp_q.push_back({(x == W - 1 && y == H - 1), 8'(model_val(x, y))});
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 2000) begin
            n_err++;
            $display("FAIL drain_timeout: %0d outputs outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        rand_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pops the scoreboard on each handshake and checks hold stability under backpressure.
    initial begin
        bit         hold_pend = 1'b0;
        logic [7:0] hold_pix;
        logic       hold_last;
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!reset && !ignore) begin
                if (hold_pend) begin
                    check("hold_valid", int'(out_valid), 1);
                    check("hold_pixel", int'(out_pixel), int'(hold_pix));
                    check("hold_last", int'(out_last), int'(hold_last));
                end
                hold_pend = out_valid && !out_ready;
                hold_pix  = out_pixel;
                hold_last = out_last;
                if (out_valid && first_cyc < 0) first_cyc = cyc;
                if (out_valid && out_ready) begin
                    out_cnt++;
                    if (out_last) last_cnt++;
                    if (out_pixel == 8'd255) sat_cnt++;
                    if (out_pixel == 8'd0) zero_cnt++;
                    if (first_val < 0) first_val = int'(out_pixel);
                    last_val = int'(out_pixel);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_output: got pixel %0d, required no output", out_pixel);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_pixel", int'(out_pixel), int'(e[7:0]));
                        check("out_last", int'(out_last), int'(e[8]));
                    end
                end
            end else begin
                hold_pend = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_pixel = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        for (int i = 0; i < KD*KD; i++) kern[i] = (i == 4) ? 1 : 0;
        clear_stats();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_pixel", int'(out_pixel), 0);
        check("reset_out_last", int'(out_last), 0);
        check("reset_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;

        // Identity ramp, full throughput.
        fill_ramp();
        clear_stats();
        send_frame(W*H, 1'b0, 1'b1);
        wait_drain();
        check("t1_count", out_cnt, 24);
        check("t1_first", first_val, 9);
        check("t1_last_val", last_val, 38);
        check("t1_last_cnt", last_cnt, 1);
        check("t1_latency", first_cyc - acc22_cyc, 2);

        // Sobel GX on a rising step.
        load_kernel(-1, 0, 1, -2, 0, 2, -1, 0, 1);
        fill_step(1'b0);
        clear_stats();
        send_frame(W*H, 1'b0, 1'b1);
        wait_drain();
        check("t2_sat", sat_cnt, 8);
        check("t2_zero", zero_cnt, 16);

        // Sobel GX on a falling step.
        fill_step(1'b1);
        clear_stats();
        send_frame(W*H, 1'b0, 1'b1);
        wait_drain();
`ifdef CONV_ABS_EN
        check("t3_sat", sat_cnt, 8);
`else
        check("t3_zero", zero_cnt, 24);
`endif

        // Identity ramp with random source gaps and random sink backpressure.
        load_kernel(0, 0, 0, 0, 1, 0, 0, 0, 0);
        fill_ramp();
        clear_stats();
        rand_rdy = 1'b1;
        send_frame(W*H, 1'b1, 1'b1);
        wait_drain();
        check("t4_count", out_cnt, 24);
        check("t4_first", first_val, 9);

        // Mid-frame reset with a random kernel, then a clean identity frame.
        for (int i = 0; i < KD*KD; i++) load_coef(i, int'($urandom_range(0, 255)) - 128);
        ignore = 1'b1;
        send_frame(20, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < KD*KD; i++) kern[i] = (i == 4) ? 1 : 0;
        ignore = 1'b0;
        @(negedge clk);
        check("t5_out_valid", int'(out_valid), 0);
        check("t5_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        clear_stats();
        send_frame(W*H, 1'b0, 1'b1);
        wait_drain();
        check("t5_count", out_cnt, 24);
        check("t5_last_val", last_val, 38);

        // Two frames back to back.
        clear_stats();
        send_frame(2*W*H, 1'b0, 1'b1);
        wait_drain();
        check("t6_count", out_cnt, 48);
        check("t6_last_cnt", last_cnt, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
